alu_rs: RTL
===========

# alu_rs

ALU reservation station: the receiving end of the ALU common-data-bus broadcast. It holds dispatched ALU instructions, wakes waiting operands by snooping CDB tag/data broadcasts, and issues ready entries to the ALU, one per cycle. It releases a slot when the CDB stage returns the finish pulse with that slot's RS number. It sits between dispatch and the ALU, and consumes the CDB stage's finish, RS-number, tag and data outputs.

## Interface
- `RS_DEPTH`, default 4: number of entries; equals 2^`aluRSWidth`.
- `TAG_W`, default `tagWidth`: ROB tag width. `tagFree` means "operand present".
- `DATA_W`, default `dataWidth`: operand and result width.
- `OP_W`, default `aluOpWidth`: ALU opcode width.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `dispValid` in 1: dispatch request.
- `dispOp` in OP_W: opcode.
- `dispTagA`, `dispTagB` in TAG_W: source tags.
- `dispDataA`, `dispDataB` in DATA_W: source values, valid when the matching tag is `tagFree`.
- `dispDestTag` in TAG_W: destination ROB tag.
- `rsFull` out 1: no free entry (combinational from registered busy bits).
- `cdbValid` in 1: CDB broadcast valid.
- `cdbTag` in TAG_W: broadcast tag.
- `cdbData` in DATA_W: broadcast data.
- `aluFinish` in 1: release request.
- `aluRSNumIn` in `aluRSWidth`: entry to release.
- `aluIssue` out 1: one-cycle issue strobe.
- `aluOp` out OP_W: issued opcode.
- `aluSrcA`, `aluSrcB` out DATA_W: issued operands.
- `aluDestTag` out TAG_W: issued destination tag.
- `aluRSNumOut` out `aluRSWidth`: issued entry index.

## Operation

Entry state:
- busy, issued, op, QA/VA, QB/VB, dest.
- An operand is ready when its Q equals `tagFree`.

Dispatch:
- Occurs when `dispValid` is high and `rsFull` is low.
- Writes the lowest-index non-busy entry.
- Sets busy=1 and issued=0.
- If `dispValid` is high while `rsFull` is high, the request is ignored; upstream must hold.

Operand capture at dispatch:
- If the dispatch tag is `tagFree`, take the dispatch data.
- Else if `cdbValid` is high and `cdbTag` equals the dispatch tag, take `cdbData` and set Q to `tagFree`. This is the same-cycle forward.
- Otherwise store the tag and wait.

Wakeup:
- Every busy entry with QA or QB equal to `cdbTag` while `cdbValid` is high latches `cdbData` into that operand and sets its Q to `tagFree`.
- Both operands may wake on one broadcast.
- A `cdbTag` equal to `tagFree` never matches.

Issue selection:
- Select the lowest-index entry that is busy, not issued, and has both operands ready, using registered state only.
- Register all ALU outputs and raise `aluIssue` for exactly one cycle.
- Set the entry's issued bit.
- At most one issue per cycle.

Release:
- On `aluFinish`, if entry `aluRSNumIn` is busy and issued, clear busy and issued.
- `aluFinish` on an entry that is idle or not issued is ignored.

Registered outputs:
- Not issuing: `aluIssue` is 0, data outputs are 0, and `aluDestTag` is `tagFree`.

Reset (`rst_n` low, immediate):
- All entries cleared.
- `aluIssue` 0, `aluOp` 0, `aluSrcA` 0, `aluSrcB` 0, `aluDestTag` `tagFree`, `aluRSNumOut` 0.
- `rsFull` is 0.
- Reset during an in-flight operation discards it. A later `aluFinish` then targets an idle entry and is ignored.

## Timing
- Dispatch with both operands ready at edge t: `aluIssue` is high in the cycle after edge t+1.
- CDB wakeup at edge t: issue is registered at edge t+1. There is no combinational CDB-to-issue bypass.
- Same-cycle dispatch forward at edge t behaves as if dispatched ready.
- A slot released at edge t becomes visible to `rsFull` and dispatch after edge t. Release and dispatch in the same cycle do not reuse that slot in that cycle.
- Release and issue in the same cycle act on different entries. An issued entry is never re-selected.
- Throughput: one issue per cycle. Slot occupancy runs from dispatch to the `aluFinish` edge.

## Structure
- Shared package holds:
  - `tagFree`
  - `tagWidth`, `dataWidth`, `aluRSWidth`, `aluOpWidth`
  - the entry record typedef (busy, issued, op, QA, VA, QB, VB, dest)
- One natural sub-module: `rs_pick_lowest`, a parameterised lowest-index one-hot plus index priority encoder. It is used twice: once for the free-slot search and once for ready selection.

## Test plan
- Dispatch with tagA = tagB = `tagFree`, A = 5, B = 7, dest = 3: one `aluIssue` pulse two edges later with `aluSrcA` 5, `aluSrcB` 7, `aluDestTag` 3, `aluRSNumOut` 0.
- Dispatch with tagA = 9; after two idle cycles, CDB broadcasts tag 9 with data 0x1234: issue one edge after the broadcast with `aluSrcA` 0x1234.
- Dispatch with tagB = 4 in the same cycle as CDB tag 4 / 0xAA: no stall cycle, and `aluSrcB` is 0xAA.
- Fill 4 entries, each waiting on tag 2: `rsFull` is 1 and a fifth dispatch is dropped. Broadcast tag 2: issues go out in order from RS 0 to RS 3, one per cycle. `aluFinish` for RS 1 clears `rsFull` on the next cycle.
- `aluFinish` for an idle RS 2: no state change. Pull `rst_n` low mid-issue: `aluIssue` drops to 0 immediately and `aluDestTag` reads `tagFree`.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared widths, the free-tag encoding and the reservation-station entry record
// for the ALU reservation station.
package alu_rs_pkg;

  localparam int tagWidth   = 6;
  localparam int dataWidth  = 32;
  localparam int aluOpWidth = 4;
  localparam int aluRSWidth = 2;

  localparam logic [tagWidth-1:0] tagFree = '0;

  typedef struct packed {
    logic                  busy;
    logic                  issued;
    logic [aluOpWidth-1:0] op;
    logic [tagWidth-1:0]   qa;
    logic [dataWidth-1:0]  va;
    logic [tagWidth-1:0]   qb;
    logic [dataWidth-1:0]  vb;
    logic [tagWidth-1:0]   dest;
  } rs_entry_t;

  // A broadcast of tagFree carries no producer, so it must never match.
  function automatic logic cdb_hit(input logic                valid,
                                   input logic [tagWidth-1:0] cdb_tag,
                                   input logic [tagWidth-1:0] tag);
    return valid && (cdb_tag != tagFree) && (cdb_tag == tag);
  endfunction

endpackage

// File: rtl/alu_rs_pick_lowest.sv
// Lowest-index priority encoder: one-hot grant, binary index and any-valid flag.
module rs_pick_lowest #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scanning from the top lets the lowest requester overwrite the others.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = W'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops, wakes operands from the CDB,
// issues one ready entry per cycle and frees slots on the ALU finish pulse.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = tagWidth,
  parameter int DATA_W   = dataWidth,
  parameter int OP_W     = aluOpWidth,
  parameter int RS_W     = $clog2(RS_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispValid,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [TAG_W-1:0]  dispTagA,
  input  logic [TAG_W-1:0]  dispTagB,
  input  logic [DATA_W-1:0] dispDataA,
  input  logic [DATA_W-1:0] dispDataB,
  input  logic [TAG_W-1:0]  dispDestTag,
  output logic              rsFull,
  input  logic              cdbValid,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData,
  input  logic              aluFinish,
  input  logic [RS_W-1:0]   aluRSNumIn,
  output logic              aluIssue,
  output logic [OP_W-1:0]   aluOp,
  output logic [DATA_W-1:0] aluSrcA,
  output logic [DATA_W-1:0] aluSrcB,
  output logic [TAG_W-1:0]  aluDestTag,
  output logic [RS_W-1:0]   aluRSNumOut
);

  rs_entry_t entries_q [RS_DEPTH];
  rs_entry_t entries_d [RS_DEPTH];

  logic [RS_DEPTH-1:0] free_req, free_onehot;
  logic [RS_DEPTH-1:0] ready_req, ready_onehot;
  logic [RS_W-1:0]     free_idx, ready_idx;
  logic                free_valid, ready_valid;
  logic                disp_fire, rel_ok;
  rs_entry_t           new_entry;

  logic              alu_issue_q, alu_issue_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_src_a_q, alu_src_a_d;
  logic [DATA_W-1:0] alu_src_b_q, alu_src_b_d;
  logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;
  logic [RS_W-1:0]   alu_rsnum_q, alu_rsnum_d;

  // Both searches look only at registered state, so there is no CDB-to-issue path.
  generate
    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_req
      assign free_req[gi]  = ~entries_q[gi].busy;
      assign ready_req[gi] = entries_q[gi].busy && !entries_q[gi].issued &&
                             (entries_q[gi].qa == tagFree) &&
                             (entries_q[gi].qb == tagFree);
    end
  endgenerate

  rs_pick_lowest #(.N(RS_DEPTH), .W(RS_W)) u_pick_free (
    .req_i    (free_req),
    .onehot_o (free_onehot),
    .idx_o    (free_idx),
    .valid_o  (free_valid)
  );

  rs_pick_lowest #(.N(RS_DEPTH), .W(RS_W)) u_pick_ready (
    .req_i    (ready_req),
    .onehot_o (ready_onehot),
    .idx_o    (ready_idx),
    .valid_o  (ready_valid)
  );

  assign rsFull    = ~free_valid;
  assign disp_fire = dispValid && free_valid;
  assign rel_ok    = aluFinish && entries_q[aluRSNumIn].busy &&
                     entries_q[aluRSNumIn].issued;

  // Incoming entry, including the same-cycle forward from the CDB.
  always_comb begin
    new_entry        = '0;
    new_entry.busy   = 1'b1;
    new_entry.issued = 1'b0;
    new_entry.op     = dispOp;
    new_entry.dest   = dispDestTag;
    if (dispTagA == tagFree) begin
      new_entry.qa = tagFree;
      new_entry.va = dispDataA;
    end else if (cdb_hit(cdbValid, cdbTag, dispTagA)) begin
      new_entry.qa = tagFree;
      new_entry.va = cdbData;
    end else begin
      new_entry.qa = dispTagA;
    end
    if (dispTagB == tagFree) begin
      new_entry.qb = tagFree;
      new_entry.vb = dispDataB;
    end else if (cdb_hit(cdbValid, cdbTag, dispTagB)) begin
      new_entry.qb = tagFree;
      new_entry.vb = cdbData;
    end else begin
      new_entry.qb = dispTagB;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy && cdb_hit(cdbValid, cdbTag, entries_q[i].qa)) begin
        entries_d[i].qa = tagFree;
        entries_d[i].va = cdbData;
      end
      if (entries_q[i].busy && cdb_hit(cdbValid, cdbTag, entries_q[i].qb)) begin
        entries_d[i].qb = tagFree;
        entries_d[i].vb = cdbData;
      end
      if (ready_onehot[i]) begin
        entries_d[i].issued = 1'b1;
      end
      if (disp_fire && free_onehot[i]) begin
        entries_d[i] = new_entry;
      end
    end
    // The released entry is busy+issued, so it is never the dispatch or issue target.
    if (rel_ok) begin
      entries_d[aluRSNumIn].busy   = 1'b0;
      entries_d[aluRSNumIn].issued = 1'b0;
    end
  end

  always_comb begin
    alu_issue_d = 1'b0;
    alu_op_d    = '0;
    alu_src_a_d = '0;
    alu_src_b_d = '0;
    alu_dest_d  = tagFree;
    alu_rsnum_d = '0;
    if (ready_valid) begin
      alu_issue_d = 1'b1;
      alu_op_d    = entries_q[ready_idx].op;
      alu_src_a_d = entries_q[ready_idx].va;
      alu_src_b_d = entries_q[ready_idx].vb;
      alu_dest_d  = entries_q[ready_idx].dest;
      alu_rsnum_d = ready_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      alu_issue_q <= 1'b0;
      alu_op_q    <= '0;
      alu_src_a_q <= '0;
      alu_src_b_q <= '0;
      alu_dest_q  <= tagFree;
      alu_rsnum_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      alu_issue_q <= alu_issue_d;
      alu_op_q    <= alu_op_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
      alu_dest_q  <= alu_dest_d;
      alu_rsnum_q <= alu_rsnum_d;
    end
  end

  assign aluIssue    = alu_issue_q;
  assign aluOp       = alu_op_q;
  assign aluSrcA     = alu_src_a_q;
  assign aluSrcB     = alu_src_b_q;
  assign aluDestTag  = alu_dest_q;
  assign aluRSNumOut = alu_rsnum_q;

endmodule
